// File: rtl/fb_pixel_generator.sv
// Pixel source for the VGA timing controller.
// Reads a 3-bit framebuffer from an external dual-port RAM one pixel ahead of the
// controller so pixel_rgb lines up with (pixel_row, pixel_col). The framebuffer is
// upscaled by 2^SCALE_SHIFT. A host write port fills the back buffer. The two
// buffers swap on request at the start of vertical blanking.
//
// Host write handshake: a write transfers on any cycle where wr_valid && wr_ready.
// wr_ready is high only while no swap is pending and reset is low. wr_ready does
// not depend on wr_valid. The host holds wr_x/wr_y/wr_rgb stable while wr_valid is
// high. The RAM write, or the wr_err pulse, appears on the following cycle.
module fb_pixel_generator #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int SCALE_SHIFT = 2,
   parameter int FB_W        = 160,
   parameter int FB_H        = 120
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  pixel_row,
   input  logic [9:0]  pixel_col,
   output logic [2:0]  pixel_rgb,
   output logic [15:0] mem_rd_addr,
   input  logic [2:0]  mem_rd_data,
   output logic        mem_wr_en,
   output logic [15:0] mem_wr_addr,
   output logic [2:0]  mem_wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_x,
   input  logic [6:0]  wr_y,
   input  logic [2:0]  wr_rgb,
   output logic        wr_err,
   input  logic        swap_req,
   output logic        swap_done,
   output logic        front_sel,
   output logic        dbg_state
);

   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

   localparam logic [15:0] FB_SIZE = 16'(FB_W * FB_H);

   state_t      state;
   logic        act_q;
   logic        swap_done_q;
   logic        wr_en_q;
   logic        wr_err_q;
   logic [9:0]  nr;
   logic [9:0]  nc;
   logic        la_act;
   logic [15:0] rd_off;
   logic        wr_accept;
   logic        wr_in_range;

   // Start address of buffer b inside the RAM
   function automatic logic [15:0] base(input logic b);
      return b ? FB_SIZE : 16'd0;
   endfunction

   // Position the controller shows next cycle, and the RAM address that feeds it
   always_comb begin
      nr = pixel_row;
      nc = pixel_col + 10'd1;
      if (pixel_col == 10'(H_TOTAL - 1)) begin
         nc = '0;
         nr = (pixel_row == 10'(V_TOTAL - 1)) ? '0 : pixel_row + 10'd1;
      end
      la_act = (nc < 10'(H_ACTIVE)) && (nr < 10'(V_ACTIVE));
      rd_off = 16'(nr >> SCALE_SHIFT) * 16'(FB_W) + 16'(nc >> SCALE_SHIFT);
      mem_rd_addr = (la_act && !reset) ? base(front_sel) + rd_off : '0;
   end

   // Host handshake decode
   always_comb begin
      wr_ready    = !reset && (state == IDLE);
      wr_accept   = wr_valid && wr_ready;
      wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
   end

   // Remember whether the pixel now arriving from the RAM is in the active area
   always_ff @(posedge clock) begin
      if (reset) act_q <= 1'b0;
      else       act_q <= la_act;
   end

   // Register an accepted write into the back buffer, or flag it as dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en_q     <= 1'b0;
         wr_err_q    <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
      end else begin
         wr_en_q  <= wr_accept && wr_in_range;
         wr_err_q <= wr_accept && !wr_in_range;
         if (wr_accept && wr_in_range) begin
            mem_wr_addr <= base(!front_sel) + 16'(wr_y) * 16'(FB_W) + 16'(wr_x);
            mem_wr_data <= wr_rgb;
         end
      end
   end

   // Swap FSM: hold a request until the first cycle of vertical blanking
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         front_sel   <= 1'b0;
         swap_done_q <= 1'b0;
      end else begin
         swap_done_q <= 1'b0;
         case (state)
            IDLE: if (swap_req) state <= PENDING;
            PENDING: begin
               if (pixel_row == 10'(V_ACTIVE) && pixel_col == 10'd0) begin
                  state       <= IDLE;
                  front_sel   <= !front_sel;
                  swap_done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs forced quiet while reset is held
   always_comb begin
      pixel_rgb = (act_q && !reset) ? mem_rd_data : 3'd0;
      mem_wr_en = wr_en_q && !reset;
      wr_err    = wr_err_q && !reset;
      swap_done = swap_done_q && !reset;
      dbg_state = (state == PENDING);
   end

endmodule
